// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and state encoding for the
// sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    localparam int BCD_MAX  = 9999;
    localparam int BCD_NDIG = 4;
    localparam int NIB_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_e;

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble correction cell:
// nibbles of 5 or more get 3 added before the shift.
module bin_to_bcd_seq_add3 (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    // add 3 so the following shift carries into the next digit
    always_comb begin
        nib_o = nib_i;
        if (nib_i >= 4'd5) nib_o = nib_i + 4'd3;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock,
// with start/busy/done handshake and saturating overflow.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W = 14,
    parameter int NDIG  = BCD_NDIG
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       ones,
    output logic [3:0]       tens,
    output logic [3:0]       hundreds,
    output logic [3:0]       thousands
);

    localparam int CNT_W = $clog2(BIN_W);
    localparam int SCR_W = NIB_W * NDIG;

    state_e             state_q;
    logic [BIN_W-1:0]   shreg_q;
    logic [BIN_W-1:0]   shreg_d;
    logic [SCR_W-1:0]   scr_q;
    logic [SCR_W-1:0]   scr_d;
    logic [SCR_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_r_q;
    logic [SCR_W-1:0]   dig_q;
    logic               busy_q;
    logic               done_q;
    logic               ovf_q;
    logic               bin_ovf;

    assign bin_ovf = int'(bin) > BCD_MAX;

    for (genvar g = 0; g < NDIG; g++) begin : g_add3
        bin_to_bcd_seq_add3 u_add3 (
            .nib_i (scr_q[g*NIB_W +: NIB_W]),
            .nib_o (adj[g*NIB_W +: NIB_W])
        );
    end

    // corrected scratch and binary shift left as one word;
    // the scratch MSB falls off (only when saturating anyway)
    always_comb begin
        {scr_d, shreg_d} = {adj, shreg_q} << 1;
    end

    // control FSM, shift registers and held result registers
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            ovf_r_q <= 1'b0;
            dig_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        shreg_q <= bin;
                        scr_q   <= '0;
                        cnt_q   <= '0;
                        ovf_r_q <= bin_ovf;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg_q <= shreg_d;
                    scr_q   <= scr_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BIN_W - 1)) state_q <= LATCH;
                end
                LATCH: begin
                    dig_q   <= ovf_r_q ? {NDIG{4'd9}} : scr_q;
                    ovf_q   <= ovf_r_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign ones      = dig_q[3:0];
    assign tens      = dig_q[7:4];
    assign hundreds  = dig_q[11:8];
    assign thousands = dig_q[15:12];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomised self-checking bench for bin_to_bcd_seq
// against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [3:0]  ones;
    logic [3:0]  tens;
    logic [3:0]  hundreds;
    logic [3:0]  thousands;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_dig = '0;
    logic        exp_ovf = 1'b0;

    always #5 clk = ~clk;

    bin_to_bcd_seq dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .start      (start),
        .bin        (bin),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .ones       (ones),
        .tens       (tens),
        .hundreds   (hundreds),
        .thousands  (thousands)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] bcd_ref(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10),
                4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic [15:0] digs();
        return {thousands, hundreds, tens, ones};
    endfunction

    // called just after the accept edge; returns #1 after done edge
    task automatic wait_done(input int v);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            chk("done_busy", {31'd0, done & busy}, 32'd0);
            if (!done) begin
                chk("hold_dig", {16'd0, digs()}, {16'd0, exp_dig});
                chk("hold_ovf", {31'd0, overflow}, {31'd0, exp_ovf});
            end
        end while (!done && n < 40);
        chk("latency", n, 15);
        exp_dig = bcd_ref(v);
        exp_ovf = (v > 9999);
        chk("digits", {16'd0, digs()}, {16'd0, exp_dig});
        chk("ovf", {31'd0, overflow}, {31'd0, exp_ovf});
        chk("busy_done", {31'd0, busy}, 32'd0);
    endtask

    // assumes DUT idle so the next edge accepts
    task automatic go(input int v, input bit hold);
        bin = 14'(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        chk("busy_acc", {31'd0, busy}, 32'd1);
        wait_done(v);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_done"}, {31'd0, done}, 32'd0);
            chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
            chk({tag, "_dig"}, {16'd0, digs()}, {16'd0, exp_dig});
            chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
        end
    endtask

    initial begin
        int v;
        int n;
        reset = 1'b0;
        start = 1'b0;
        bin   = '0;
        #1;
        chk("rst_dig", {16'd0, digs()}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // idle after reset
        idle_cycles(10, "idle");

        // single conversion
        go(1234, 0);
        idle_cycles(3, "post1234");

        // back-to-back with start held high
        go(0, 1);
        go(9999, 1);
        go(10, 0);

        // overflow saturation then recovery
        go(10000, 0);
        go(16383, 0);
        go(42, 0);

        // start/bin noise while busy must be ignored
        bin = 14'd321;
        start = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        do begin
            bin = 14'd7777;
            start = (n >= 13) ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
            chk("n_done_busy", {31'd0, done & busy}, 32'd0);
        end while (!done && n < 40);
        start = 1'b0;
        chk("n_latency", n, 15);
        exp_dig = bcd_ref(321);
        exp_ovf = 1'b0;
        chk("n_digits", {16'd0, digs()}, {16'd0, exp_dig});
        idle_cycles(20, "noise");

        // reset mid-shift
        go(1111, 0);
        bin = 14'd5678;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        exp_dig = '0;
        exp_ovf = 1'b0;
        chk("mr_dig", {16'd0, digs()}, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle_cycles(20, "mr_idle");
        go(5678, 0);

        // randomised conversions with random gaps
        for (int i = 0; i < 30; i++) begin
            v = (i % 4 == 3) ? int'($urandom_range(10000, 16383))
                             : int'($urandom_range(0, 9999));
            go(v, 0);
            idle_cycles(int'($urandom_range(0, 3)), "gap");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got 1 exp 0");
        $fatal(1, "timeout");
    end

endmodule
